// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter and its picker.
// Holds the arbiter state encoding, UART defaults and a wrap-add helper.
package uart_arb_pkg;

  localparam int UART_DATA_W     = 8;
  localparam int UART_BIT_CYCLES = 5200;

  typedef enum logic [2:0] {
    ARB,
    SEND,
    HOLD,
    WAIT,
    OWN
  } arbState_t;

  function automatic int wrapAdd(
    input int a,
    input int b,
    input int n
  );
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set bit above ptr, wrapping.
// Ports: reqVec/ptr in; hit (any request) and idx (winner) out.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         reqVec,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 hit,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  // Scan offsets high to low so the nearest one after ptr wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int off = N; off >= 1; off--) begin
      for (int j = 0; j < N; j++) begin
        if (reqVec[j] && j == wrapAdd(int'(ptr), off, N)) begin
          hit = 1'b1;
          idx = IW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter sharing one UART transmitter.
// Ports: req_* byte streams in, tx_* start/data to UART, arb_* status out.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = UART_DATA_W,
  parameter int LOCK_TIMEOUT = 52000
) (
  input  logic                       sys_clk,
  input  logic                       sys_resetL,
  input  logic [NUM_REQ-1:0]         req_validH,
  input  logic [NUM_REQ*DATA_W-1:0]  req_dataH,
  input  logic [NUM_REQ-1:0]         req_lastH,
  output logic [NUM_REQ-1:0]         req_readyH,
  output logic                       tx_startH,
  output logic [DATA_W-1:0]          tx_dataH,
  input  logic                       tx_busyH,
  output logic [$clog2(NUM_REQ)-1:0] arb_ownerH,
  output logic                       arb_lockedH,
  output logic                       timeout_errH
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CNT_W =
    (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] TO_MAX =
    CNT_W'(LOCK_TIMEOUT - 1);

  arbState_t        state;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    gnt;
  logic [CNT_W-1:0] idleCnt;
  logic             lastQ;
  logic             pickHit;
  logic [IW-1:0]    pickIdx;

  uart_rr_pick #(
    .N (NUM_REQ)
  ) uPick (
    .reqVec (req_validH),
    .ptr    (ptr),
    .hit    (pickHit),
    .idx    (pickIdx)
  );

  assign arb_ownerH = gnt;

  always_comb begin
    tx_dataH = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tx_startH && gnt == IW'(i)) begin
        tx_dataH = req_dataH[i*DATA_W +: DATA_W];
      end
    end
  end

  // tx_startH/req_readyH are registered on the edge into SEND,
  // so they are high exactly for the single SEND cycle.
  always_ff @(posedge sys_clk or negedge sys_resetL) begin
    if (!sys_resetL) begin
      state        <= ARB;
      ptr          <= IW'(NUM_REQ - 1);
      gnt          <= '0;
      idleCnt      <= '0;
      lastQ        <= 1'b0;
      tx_startH    <= 1'b0;
      req_readyH   <= '0;
      arb_lockedH  <= 1'b0;
      timeout_errH <= 1'b0;
    end else begin
      tx_startH    <= 1'b0;
      req_readyH   <= '0;
      timeout_errH <= 1'b0;
      unique case (state)
        ARB: begin
          if (pickHit) begin
            gnt         <= pickIdx;
            arb_lockedH <= 1'b1;
            tx_startH   <= 1'b1;
            req_readyH  <= NUM_REQ'(1) << pickIdx;
            state       <= SEND;
          end
        end
        SEND: begin
          lastQ <= req_lastH[gnt];
          state <= HOLD;
        end
        HOLD: state <= WAIT;
        WAIT: begin
          if (!tx_busyH) begin
            if (lastQ) begin
              ptr         <= gnt;
              arb_lockedH <= 1'b0;
              state       <= ARB;
            end else begin
              idleCnt <= '0;
              state   <= OWN;
            end
          end
        end
        OWN: begin
          // Timeout beats a same-cycle owner request.
          if (idleCnt == TO_MAX) begin
            timeout_errH <= 1'b1;
            ptr          <= gnt;
            arb_lockedH  <= 1'b0;
            state        <= ARB;
          end else if (req_validH[gnt]) begin
            tx_startH  <= 1'b1;
            req_readyH <= NUM_REQ'(1) << gnt;
            state      <= SEND;
          end else begin
            idleCnt <= idleCnt + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a UART busy/line model.
// Directed vectors plus sequences for lock, timeout and reset cases.
module tb_uart_tx_arbiter;
  import uart_arb_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int LT = 16;

  logic           sys_clk = 1'b0;
  logic           sys_resetL;
  logic [N-1:0]   req_validH;
  logic [N*W-1:0] req_dataH;
  logic [N-1:0]   req_lastH;
  logic [N-1:0]   req_readyH;
  logic           tx_startH;
  logic [W-1:0]   tx_dataH;
  logic           tx_busyH;
  logic [1:0]     arb_ownerH;
  logic           arb_lockedH;
  logic           timeout_errH;

  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .DATA_W       (W),
    .LOCK_TIMEOUT (LT)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_resetL   (sys_resetL),
    .req_validH   (req_validH),
    .req_dataH    (req_dataH),
    .req_lastH    (req_lastH),
    .req_readyH   (req_readyH),
    .tx_startH    (tx_startH),
    .tx_dataH     (tx_dataH),
    .tx_busyH     (tx_busyH),
    .arb_ownerH   (arb_ownerH),
    .arb_lockedH  (arb_lockedH),
    .timeout_errH (timeout_errH)
  );

  typedef struct {
    logic [3:0] mask;
    logic [1:0] expOwner;
    logic [7:0] expData;
  } vec_t;

  vec_t vecs[10];

  int nChecks = 0;
  int nFail   = 0;

  logic [8:0] fifo[N][16];
  int head[N];
  int tail[N];

  int cycle = 0;
  int startCount = 0;
  int toCount = 0;
  int toCycle = 0;
  int readyBad = 0;

  logic         sStart, sBusy, sLocked, sTimeout;
  logic [W-1:0] sData;
  logic [1:0]   sOwner;
  logic [N-1:0] sReady;

  int         bitCycles = 2;
  int         elapsed = 0;
  logic [9:0] frame;
  logic       uart_XMIT_dataH;
  logic       lineBits[16];
  int         nBits = 0;

  task automatic check(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (head[i] != tail[i]) begin
        req_validH[i] = 1'b1;
        {req_lastH[i], req_dataH[i*W +: W]} = fifo[i][head[i] % 16];
      end else begin
        req_validH[i] = 1'b0;
        req_lastH[i] = 1'b0;
        req_dataH[i*W +: W] = '0;
      end
    end
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    fifo[i][tail[i] % 16] = {l, d};
    tail[i]++;
    drive();
  endtask

  task automatic clearQ();
    for (int i = 0; i < N; i++) head[i] = tail[i];
    drive();
  endtask

  function automatic bit allEmpty();
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(negedge sys_clk);
    cycle++;
    sStart   = tx_startH;
    sData    = tx_dataH;
    sOwner   = arb_ownerH;
    sReady   = req_readyH;
    sLocked  = arb_lockedH;
    sTimeout = timeout_errH;
    sBusy    = tx_busyH;
    if (sReady !== (sStart ? (4'b0001 << sOwner) : 4'b0000)) readyBad++;
    if (sStart) startCount++;
    if (sTimeout) begin
      toCount++;
      toCycle = cycle;
    end
    @(posedge sys_clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (sReady[i] && head[i] != tail[i]) head[i]++;
    end
    if (tx_busyH) begin
      elapsed++;
      if (elapsed >= 10 * bitCycles) tx_busyH = 1'b0;
    end
    if (sStart && sys_resetL) begin
      tx_busyH = 1'b1;
      frame = {1'b1, sData, 1'b0};
      elapsed = 0;
    end
    uart_XMIT_dataH = tx_busyH ? frame[elapsed / bitCycles] : 1'b1;
    if (tx_busyH && (elapsed % bitCycles) == bitCycles / 2 && nBits < 16) begin
      lineBits[nBits] = uart_XMIT_dataH;
      nBits++;
    end
    drive();
  endtask

  task automatic waitStart(
    input int bound,
    output logic [1:0] own,
    output logic [7:0] dat
  );
    bit ok;
    ok = 1'b0;
    own = '0;
    dat = '0;
    for (int k = 0; k < bound; k++) begin
      tick();
      if (sStart) begin
        own = sOwner;
        dat = sData;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      nChecks++;
      nFail++;
      $display("FAIL wait_start: got no tx_startH, expected one within %0d cycles", bound);
    end
  endtask

  task automatic waitIdle(input int bound);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      tick();
      if (!sBusy && !tx_busyH && !sLocked && !sStart && allEmpty()) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      nChecks++;
      nFail++;
      $display("FAIL wait_idle: got still active, expected idle within %0d cycles", bound);
    end
  endtask

  task automatic waitBusyLow(output int c1);
    c1 = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (!sBusy) begin
        c1 = cycle;
        break;
      end
    end
    check("busy_low_seen", (c1 != 0), 1);
  endtask

  task automatic waitTimeout(input int to0);
    for (int k = 0; k < 60; k++) begin
      if (toCount != to0) break;
      tick();
    end
    check("timeout_seen", toCount - to0, 1);
  endtask

  task automatic checkZero(input string tag);
    check({tag, "_start"},  tx_startH,    0);
    check({tag, "_data"},   tx_dataH,     0);
    check({tag, "_ready"},  req_readyH,   0);
    check({tag, "_owner"},  arb_ownerH,   0);
    check({tag, "_locked"}, arb_lockedH,  0);
    check({tag, "_toerr"},  timeout_errH, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] own;
    logic [7:0] dat;
    int c1, s0, to0;
    logic expBits[10];

    vecs[0] = '{4'b0001, 2'd0, 8'h10};
    vecs[1] = '{4'b0011, 2'd1, 8'h11};
    vecs[2] = '{4'b0011, 2'd0, 8'h10};
    vecs[3] = '{4'b1010, 2'd1, 8'h11};
    vecs[4] = '{4'b1010, 2'd3, 8'h13};
    vecs[5] = '{4'b1111, 2'd0, 8'h10};
    vecs[6] = '{4'b0100, 2'd2, 8'h12};
    vecs[7] = '{4'b0101, 2'd0, 8'h10};
    vecs[8] = '{4'b1001, 2'd3, 8'h13};
    vecs[9] = '{4'b1001, 2'd0, 8'h10};

    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    tx_busyH = 1'b0;
    uart_XMIT_dataH = 1'b1;
    drive();
    sys_resetL = 1'b1;
    #2;
    sys_resetL = 1'b0;
    #1;
    checkZero("reset");
    tick();
    tick();
    sys_resetL = 1'b1;
    tick();

    // Table: one-byte packets, losers withdraw after the grant.
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < N; i++) begin
        if (vecs[v].mask[i]) push(i, 8'h10 + 8'(i), 1'b1);
      end
      waitStart(50, own, dat);
      clearQ();
      check($sformatf("vec%0d_owner", v), own, vecs[v].expOwner);
      check($sformatf("vec%0d_data", v), dat, vecs[v].expData);
      waitIdle(200);
    end

    // Two requesters held continuously alternate.
    push(0, 8'hA0, 1'b1);
    push(0, 8'hA1, 1'b1);
    push(1, 8'hB0, 1'b1);
    push(1, 8'hB1, 1'b1);
    waitStart(50, own, dat);
    check("rr0", {own, dat}, {2'd1, 8'hB0});
    waitStart(100, own, dat);
    check("rr1", {own, dat}, {2'd0, 8'hA0});
    waitStart(100, own, dat);
    check("rr2", {own, dat}, {2'd1, 8'hB1});
    waitStart(100, own, dat);
    check("rr3", {own, dat}, {2'd0, 8'hA1});
    waitIdle(200);

    // Single two-byte packet from requester 2.
    s0 = startCount;
    push(2, 8'h61, 1'b0);
    push(2, 8'h62, 1'b1);
    waitStart(50, own, dat);
    check("pkt_b0", {own, dat}, {2'd2, 8'h61});
    waitStart(100, own, dat);
    check("pkt_b1", {own, dat}, {2'd2, 8'h62});
    waitIdle(200);
    check("pkt_starts", startCount - s0, 2);
    check("pkt_unlocked", sLocked, 0);

    // Lock hold: requester 0 waits for all of requester 3's packet.
    push(3, 8'h71, 1'b0);
    push(3, 8'h72, 1'b0);
    push(3, 8'h73, 1'b1);
    waitStart(50, own, dat);
    check("lock_b0", {own, dat}, {2'd3, 8'h71});
    push(0, 8'h0A, 1'b1);
    waitStart(100, own, dat);
    check("lock_b1", {own, dat}, {2'd3, 8'h72});
    waitStart(100, own, dat);
    check("lock_b2", {own, dat}, {2'd3, 8'h73});
    waitStart(100, own, dat);
    check("lock_next", {own, dat}, {2'd0, 8'h0A});
    waitIdle(200);

    // Timeout: owner 1 goes idle mid-packet, requester 2 waits.
    push(1, 8'h31, 1'b0);
    waitStart(50, own, dat);
    check("to_first", {own, dat}, {2'd1, 8'h31});
    push(2, 8'h41, 1'b1);
    s0 = startCount;
    waitBusyLow(c1);
    to0 = toCount;
    waitTimeout(to0);
    check("to_delay", toCycle - c1, 17);
    check("to_no_start", startCount - s0, 0);
    check("to_unlocked", sLocked, 0);
    waitStart(50, own, dat);
    check("to_next", {own, dat}, {2'd2, 8'h41});
    waitIdle(200);

    // Owner byte arrives on the timeout cycle: timeout wins.
    push(1, 8'h32, 1'b0);
    waitStart(50, own, dat);
    check("sim_first", {own, dat}, {2'd1, 8'h32});
    s0 = startCount;
    waitBusyLow(c1);
    to0 = toCount;
    while (cycle < c1 + 15) tick();
    push(1, 8'h33, 1'b1);
    waitTimeout(to0);
    check("sim_delay", toCycle - c1, 17);
    check("sim_no_start", startCount - s0, 0);
    waitStart(50, own, dat);
    check("sim_rearb", {own, dat}, {2'd1, 8'h33});
    waitIdle(200);

    // Reset asserted while waiting on the transmitter.
    push(2, 8'h51, 1'b1);
    waitStart(50, own, dat);
    check("rst_grant", {own, dat}, {2'd2, 8'h51});
    repeat (5) tick();
    check("rst_pre_locked", arb_lockedH, 1);
    check("rst_pre_owner", arb_ownerH, 2);
    sys_resetL = 1'b0;
    #1;
    checkZero("midrst");
    tx_busyH = 1'b0;
    uart_XMIT_dataH = 1'b1;
    clearQ();
    tick();
    tick();
    sys_resetL = 1'b1;
    push(3, 8'h53, 1'b1);
    push(1, 8'h52, 1'b1);
    waitStart(50, own, dat);
    check("rst_first", {own, dat}, {2'd1, 8'h52});
    waitIdle(200);

    // Full-rate frame on the line model.
    bitCycles = UART_BIT_CYCLES;
    nBits = 0;
    push(1, 8'hA5, 1'b1);
    waitStart(50, own, dat);
    check("line_grant", {own, dat}, {2'd1, 8'hA5});
    waitIdle(60000);
    expBits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    check("line_nbits", nBits, 10);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("line_bit%0d", i), lineBits[i], expBits[i]);
    end

    check("ready_onehot", readyBad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter among `NUM_REQ` byte-stream requesters. A grant is packet-locked: the winner keeps the transmitter until it sends a byte flagged `last`, or until it idles past `LOCK_TIMEOUT`. The arbiter sits between the requester clients and the `uart` transmit path, which drives `uart_XMIT_dataH`. It issues one start pulse per byte and waits for the transmitter's busy to clear before issuing the next.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_W`, 8: byte width.
- `LOCK_TIMEOUT`, 52000: idle cycles in a locked packet before the lock is forcibly released (10 bit times at 100 MHz / 19200 baud).
- `sys_clk`  in  1: system clock, 100 MHz.
- `sys_resetL`  in  1: asynchronous, active-low reset.
- `req_validH`  in  NUM_REQ: per-requester byte available.
- `req_dataH`  in  NUM_REQ*DATA_W: packed bytes; requester i occupies bits [i*DATA_W +: DATA_W].
- `req_lastH`  in  NUM_REQ: byte is the end of a packet.
- `req_readyH`  out  NUM_REQ: one-hot byte-accepted pulse.
- `tx_startH`  out  1: one-cycle start pulse to the transmitter.
- `tx_dataH`  out  DATA_W: byte to transmit; valid while `tx_startH`=1.
- `tx_busyH`  in  1: transmitter busy. It must rise on the cycle after `tx_startH` and stay high through the stop bit.
- `arb_ownerH`  out  clog2(NUM_REQ): current or last grantee.
- `arb_lockedH`  out  1: a packet lock is held.
- `timeout_errH`  out  1: one-cycle pulse on forced lock release.

## Operation
- Requester rules:
  - Hold `req_dataH` and `req_lastH` stable while `req_validH` is high, until `req_readyH` is seen.
  - Withdrawing `req_validH` before `req_readyH` cancels the byte; nothing is sent for it.
- State `ARB`:
  - Search from (`ptr`+1) mod NUM_REQ upward, wrapping, for the first set `req_validH`.
  - On a hit: `gnt` <= index, `arb_lockedH` <= 1, go to `SEND`.
  - On no hit: stay in `ARB`.
- State `SEND` (exactly one cycle):
  - `tx_startH`=1 and `tx_dataH`=byte of `gnt` (combinational mux).
  - `req_readyH[gnt]`=1.
  - Latch `req_lastH[gnt]` into `last_q`, then go to `HOLD`.
- State `HOLD` (exactly one cycle): ignore `tx_busyH`, then go to `WAIT`.
- State `WAIT`: stay while `tx_busyH`=1. Once it is 0:
  - If `last_q`=1: `ptr` <= `gnt`, `arb_lockedH` <= 0, go to `ARB`.
  - Otherwise: clear `idle_cnt`, go to `OWN`.
- State `OWN`:
  - If `req_validH[gnt]`=1: go to `SEND`. Other requesters are ignored.
  - Otherwise increment `idle_cnt`. When `idle_cnt` reaches LOCK_TIMEOUT-1: pulse `timeout_errH`, `ptr` <= `gnt`, `arb_lockedH` <= 0, go to `ARB`.
- Fairness: after a packet ends, the finishing requester has the lowest priority. No requester can win twice in a row while another is valid.
- Simultaneous events:
  - `req_validH[gnt]` rising in the same cycle as the timeout: the timeout wins, and the byte is re-arbitrated in `ARB`.
  - A request from a non-owner during a lock waits; it is not dropped.
- Reset (asynchronous; mid-operation is allowed):
  - State `ARB`, `ptr`=NUM_REQ-1 (requester 0 has priority first), `gnt`=0, `idle_cnt`=0, `last_q`=0.
  - `tx_startH`, `tx_dataH`, `req_readyH`, `arb_ownerH`, `arb_lockedH` and `timeout_errH` all 0.
  - Outputs clear immediately on reset assertion, not at the next edge. A byte already started on the line is abandoned; the transmitter is responsible for its own reset.

## Timing
- `req_validH` sampled high in `ARB` at edge k → `tx_startH`=1 during cycle k..k+1. The transmitter captures the byte at edge k+1.
- Next byte of a locked packet: earliest `SEND` is the cycle after `tx_busyH` is sampled low.
- Per-byte overhead: 2 cycles plus the transmitter's busy time, when the owner keeps `req_validH` high.
- Packet end → next grant: 1 cycle in `ARB` plus 1 cycle to `SEND`.
- `arb_ownerH` updates on the edge entering `SEND` from `ARB`.
- `idle_cnt` width: clog2(LOCK_TIMEOUT). The counter saturates and never wraps.

## Structure
- Package `uart_arb_pkg` holds:
  - the state encoding `ARB`/`SEND`/`HOLD`/`WAIT`/`OWN`;
  - the default constants `UART_DATA_W`=8 and `UART_BIT_CYCLES`=5200.
- Sub-module `uart_rr_pick`: combinational round-robin picker (inputs: request vector, `ptr`; outputs: hit, index). It is reused by later receive-side distribution logic.

## Test plan
- Single packet: requester 2 sends 0x61, 0x62 (`last`); bench busy model holds busy 20 cycles → `tx_dataH` sequence 0x61, 0x62 with `gnt`=2, exactly two `tx_startH` pulses, then `arb_lockedH`=0.
- Round robin: requesters 0 and 1 each hold one 1-byte packet continuously → grants alternate 0,1,0,1; no requester is granted twice consecutively.
- Lock hold: requester 3 is mid-packet (3 bytes) while requester 0 requests → all three bytes of requester 3 go out before 0x?? of requester 0; `req_readyH[0]` stays 0 until the lock is released.
- Timeout: with LOCK_TIMEOUT=16, owner 1 sends a non-`last` byte then drops valid → `timeout_errH` pulses exactly 16 cycles after entering `OWN`; requester 2 is granted next.
- Reset mid-`WAIT`: assert `sys_resetL`=0 while busy → all outputs 0 immediately. After release, the first grant goes to the lowest-index valid requester.
- Full-rate line check: `uart` transmitter plus arbiter, 5200-cycle bits, byte 0xA5 from requester 1 → `uart_XMIT_dataH` shows start bit, LSB-first 1,0,1,0,0,1,0,1, stop bit, at 52000 ns per bit.
